// File: rtl/stage_if.sv
// Instruction fetch stage: one outstanding imem request, a 2-entry
// {pc, inst} queue toward decode, and redirect handling that drops
// in-flight responses via a discard flag.
module stage_if #(
   parameter int unsigned           ADDR_WIDTH = 64,
   parameter int unsigned           INST_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  redirect,
   input  logic [1:0]            pc_sel,
   input  logic [ADDR_WIDTH-1:0] bra_addr,
   input  logic [ADDR_WIDTH-1:0] jal_addr,
   input  logic [ADDR_WIDTH-1:0] jar_addr,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_ready,
   input  logic                  imem_rvalid,
   input  logic [INST_WIDTH-1:0] imem_rdata,
   output logic                  inst_valid,
   output logic [INST_WIDTH-1:0] inst_word,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic [ADDR_WIDTH-1:0] pc4
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t                           state_q;
   logic [ADDR_WIDTH-1:0]            fetch_pc_q;
   logic [ADDR_WIDTH-1:0]            req_pc_q;
   logic                             discard_q;
   logic [1:0]                       count_q, count_d;
   logic [1:0][ADDR_WIDTH-1:0]       fifo_pc_q;
   logic [1:0][INST_WIDTH-1:0]       fifo_inst_q;

   logic                             flush, push, pop, wr_idx;
   logic [1:0]                       count_m1;
   logic [ADDR_WIDTH-1:0]            target;

   // Target select, flush/push/pop qualification and next queue occupancy.
   always_comb begin
      target = '0;
      case (pc_sel)
         2'b01:   target = bra_addr;
         2'b10:   target = jal_addr;
         2'b11:   target = jar_addr;
         default: target = '0;
      endcase
      target[1:0] = 2'b00;
      // pc_sel == 00 is not a redirect at all
      flush    = redirect && (pc_sel != 2'b00);
      pop      = (count_q != 2'd0) && !stall && !flush;
      push     = (state_q == WAIT) && imem_rvalid && !discard_q && !flush;
      count_d  = count_q;
      if (push && !pop)
         count_d = count_q + 2'd1;
      else if (pop && !push)
         count_d = count_q - 2'd1;
      // with a simultaneous pop the new entry lands one slot lower
      count_m1 = count_q - 2'd1;
      wr_idx   = pop ? count_m1[0] : count_q[0];
   end

   // Two-entry queue; slot 0 is always the head, pops shift slot 1 down.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q     <= 2'd0;
         fifo_pc_q   <= '0;
         fifo_inst_q <= '0;
      end else if (flush) begin
         count_q <= 2'd0;
      end else begin
         count_q <= count_d;
         if (pop) begin
            fifo_pc_q[0]   <= fifo_pc_q[1];
            fifo_inst_q[0] <= fifo_inst_q[1];
         end
         if (push) begin
            fifo_pc_q[wr_idx]   <= req_pc_q;
            fifo_inst_q[wr_idx] <= imem_rdata;
         end
      end
   end

   // Fetch FSM: issue, wait for the single response, track discard on redirect.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
         discard_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (flush) begin
                  fetch_pc_q <= target;
                  state_q    <= REQ;
               end else if (count_q < 2'd2) begin
                  state_q <= REQ;
               end
            end
            REQ: begin
               if (imem_ready) begin
                  req_pc_q   <= fetch_pc_q;
                  state_q    <= WAIT;
                  // the accepted request is already stale if we redirect now
                  discard_q  <= flush;
                  fetch_pc_q <= flush ? target : fetch_pc_q + ADDR_WIDTH'(4);
               end else if (flush) begin
                  fetch_pc_q <= target;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  discard_q <= 1'b0;
                  if (flush) begin
                     fetch_pc_q <= target;
                     state_q    <= REQ;
                  end else begin
                     state_q <= (count_d < 2'd2) ? REQ : IDLE;
                  end
               end else if (flush) begin
                  discard_q  <= 1'b1;
                  fetch_pc_q <= target;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign imem_req   = (state_q == REQ);
   assign imem_addr  = fetch_pc_q;
   assign inst_valid = (count_q != 2'd0);
   assign inst_word  = fifo_inst_q[0];
   assign pc         = fifo_pc_q[0];
   assign pc4        = fifo_pc_q[0] + ADDR_WIDTH'(4);

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: behavioural instruction memory, scoreboard of
// expected {pc, inst} entries, directed redirect/stall/wrap/reset steps.
module tb_stage_if;

   logic        clk = 1'b0;
   logic        reset, stall, redirect;
   logic [1:0]  pc_sel;
   logic [63:0] bra_addr, jal_addr, jar_addr;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ready, imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst_word;
   logic [63:0] pc, pc4;

   localparam logic [63:0] SENT = 64'hDEAD_BEEF_DEAD_BEEF;

   stage_if dut (
      .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .pc_sel(pc_sel),
      .bra_addr(bra_addr), .jal_addr(jal_addr), .jar_addr(jar_addr),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst_word(inst_word), .pc(pc), .pc4(pc4)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int mem_lat = 1;
   int acc_cnt = 0;

   typedef struct { logic [63:0] pc; logic [31:0] inst; } ent_t;
   ent_t        sb_q[$];
   logic [63:0] acc_log[$];
   logic [63:0] pop_pc_log[$];
   logic [63:0] pop_pc4_log[$];

   function automatic logic [31:0] f_inst(input logic [63:0] a);
      return a[31:0] ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_acc(input string tag);
      int  c;
      logic ok;
      c  = acc_cnt;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step(1);
         if (acc_cnt != c) begin ok = 1'b1; break; end
      end
      chk(tag, ok, 1'b1);
   endtask

   // Memory: accept observed mid-cycle, one response mem_lat cycles later.
   initial begin
      logic [63:0] a;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      forever begin
         @(negedge clk);
         if (imem_req === 1'b1 && imem_ready) begin
            a = imem_addr;
            @(posedge clk);
            repeat (mem_lat - 1) @(posedge clk);
            #1;
            imem_rvalid = 1'b1;
            imem_rdata  = f_inst(a);
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
         end
      end
   end

   // Scoreboard: expected queue contents, expected fetch address, stale tracking.
   logic [63:0] exp_fetch = '0;
   logic [63:0] paddr = '0;
   logic        pending = 1'b0, stale = 1'b0, prev_rst = 1'b0;
   always @(negedge clk) begin
      logic        redir_b, accept;
      logic [63:0] tgt;
      ent_t        e;
      redir_b = redirect && (pc_sel != 2'b00);
      accept  = imem_req && imem_ready;
      case (pc_sel)
         2'b01:   tgt = bra_addr;
         2'b10:   tgt = jal_addr;
         2'b11:   tgt = jar_addr;
         default: tgt = '0;
      endcase
      tgt[1:0] = 2'b00;
      if (reset) begin
         if (prev_rst) begin
            chk("rst_imem_req", imem_req, 1'b0);
            chk("rst_inst_valid", inst_valid, 1'b0);
            chk("rst_inst_word", inst_word, 32'h0);
            chk("rst_pc", pc, 64'h0);
            chk("rst_pc4", pc4, 64'h4);
            chk("rst_imem_addr", imem_addr, 64'h0);
         end
         sb_q.delete();
         pending   = 1'b0;
         stale     = 1'b0;
         exp_fetch = '0;
      end else begin
         chk("inst_valid", inst_valid, sb_q.size() != 0);
         chk("imem_addr", imem_addr, exp_fetch);
         if (sb_q.size() >= 2) chk("imem_req_full", imem_req, 1'b0);
         if (redir_b) begin
            sb_q.delete();
            if (pending) stale = 1'b1;
         end else if (sb_q.size() != 0 && !stall) begin
            e = sb_q.pop_front();
            chk("head_pc", pc, e.pc);
            chk("head_inst", inst_word, e.inst);
            chk("head_pc4", pc4, e.pc + 64'd4);
            pop_pc_log.push_back(pc);
            pop_pc4_log.push_back(pc4);
         end
         if (imem_rvalid && pending) begin
            if (!stale && !redir_b) begin
               e.pc   = paddr;
               e.inst = f_inst(paddr);
               sb_q.push_back(e);
            end
            pending = 1'b0;
         end
         chk("fifo_depth_ok", sb_q.size() <= 2, 1'b1);
         if (accept) begin
            pending = 1'b1;
            stale   = redir_b;
            paddr   = imem_addr;
            acc_log.push_back(imem_addr);
            acc_cnt++;
         end
         exp_fetch = redir_b ? tgt : (accept ? exp_fetch + 64'd4 : exp_fetch);
      end
      prev_rst = reset;
   end

   initial begin
      int          na, np, idx;
      logic [63:0] lastpc, olda;
      logic        found;
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; pc_sel = 2'b00;
      bra_addr = '0; jal_addr = '0; jar_addr = '0; imem_ready = 1'b1;
      step(4);
      chk("rst_req_direct", imem_req, 1'b0);
      chk("rst_pc4_direct", pc4, 64'h4);

      // sequential fetch from reset
      reset = 1'b0;
      step(14);
      chk("seq_acc0", acc_log.size() > 0 ? acc_log[0] : SENT, 64'h0);
      chk("seq_acc1", acc_log.size() > 1 ? acc_log[1] : SENT, 64'h4);
      chk("seq_acc2", acc_log.size() > 2 ? acc_log[2] : SENT, 64'h8);
      chk("seq_pop0_pc", pop_pc_log.size() > 0 ? pop_pc_log[0] : SENT, 64'h0);
      chk("seq_pop0_pc4", pop_pc4_log.size() > 0 ? pop_pc4_log[0] : SENT, 64'h4);
      chk("seq_pop1_pc", pop_pc_log.size() > 1 ? pop_pc_log[1] : SENT, 64'h4);

      // stall fills the queue, fetch stops, head holds
      lastpc = pop_pc_log[$];
      stall  = 1'b1;
      step(8);
      chk("stall_req", imem_req, 1'b0);
      chk("stall_valid", inst_valid, 1'b1);
      chk("stall_head_pc", pc, lastpc + 64'd4);
      np = pop_pc_log.size();
      na = acc_log.size();
      stall = 1'b0;
      step(8);
      chk("unstall_pop0", pop_pc_log.size() > np ? pop_pc_log[np] : SENT, lastpc + 64'd4);
      chk("unstall_pop1", pop_pc_log.size() > np + 1 ? pop_pc_log[np + 1] : SENT, lastpc + 64'd8);
      chk("unstall_fetch", acc_log.size() > na, 1'b1);

      // redirect while waiting on a response
      mem_lat = 3;
      wait_acc("wait_acc_046");
      redirect = 1'b1; pc_sel = 2'b10; jal_addr = 64'h103;
      step(1);
      redirect = 1'b0; pc_sel = 2'b00;
      chk("r046_valid", inst_valid, 1'b0);
      na = acc_log.size();
      wait_acc("wait_acc_046b");
      chk("r046_addr", acc_log.size() > na ? acc_log[na] : SENT, 64'h100);
      step(6);

      // redirect coincident with acceptance
      mem_lat    = 1;
      imem_ready = 1'b0;
      found      = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (imem_req) begin found = 1'b1; break; end
         step(1);
      end
      chk("wait_req_047", found, 1'b1);
      olda       = imem_addr;
      imem_ready = 1'b1;
      redirect   = 1'b1; pc_sel = 2'b01; bra_addr = 64'h200;
      na = acc_log.size();
      np = pop_pc_log.size();
      step(1);
      redirect = 1'b0; pc_sel = 2'b00;
      chk("r047_old_acc", acc_log.size() > na ? acc_log[na] : SENT, olda);
      wait_acc("wait_acc_047");
      chk("r047_addr", acc_log.size() > na + 1 ? acc_log[na + 1] : SENT, 64'h200);
      step(8);
      found = 1'b0;
      for (int i = np; i < pop_pc_log.size(); i++)
         if (pop_pc_log[i] == olda) found = 1'b1;
      chk("r047_stale_out", found, 1'b0);

      // redirect coincident with a response and a pop
      stall   = 1'b1;
      mem_lat = 2;
      found   = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step(1);
         if (imem_rvalid && sb_q.size() >= 1) begin found = 1'b1; break; end
      end
      chk("wait_rv_048", found, 1'b1);
      chk("r048_pre_valid", inst_valid, 1'b1);
      stall = 1'b0;
      redirect = 1'b1; pc_sel = 2'b11; jar_addr = 64'h300;
      step(1);
      redirect = 1'b0; pc_sel = 2'b00;
      chk("r048_valid", inst_valid, 1'b0);
      na = acc_log.size();
      wait_acc("wait_acc_048");
      chk("r048_addr", acc_log.size() > na ? acc_log[na] : SENT, 64'h300);
      step(6);

      // address wrap at the top of the space
      mem_lat  = 1;
      redirect = 1'b1; pc_sel = 2'b11; jar_addr = 64'hFFFF_FFFF_FFFF_FFFE;
      step(1);
      redirect = 1'b0; pc_sel = 2'b00;
      na = acc_log.size();
      np = pop_pc_log.size();
      step(12);
      chk("wrap_acc0", acc_log.size() > na ? acc_log[na] : SENT, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_acc1", acc_log.size() > na + 1 ? acc_log[na + 1] : SENT, 64'h0);
      idx = -1;
      for (int i = np; i < pop_pc_log.size(); i++)
         if (idx < 0 && pop_pc_log[i] == 64'hFFFF_FFFF_FFFF_FFFC) idx = i;
      chk("wrap_pc4", idx >= 0 ? pop_pc4_log[idx] : SENT, 64'h0);

      // reset in the middle of a transaction; late response lands in IDLE
      mem_lat = 2;
      wait_acc("wait_acc_rst");
      np    = pop_pc_log.size();
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      step(10);
      chk("rst_mid_pop", pop_pc_log.size() > np ? pop_pc_log[np] : SENT, 64'h0);
      chk("rst_mid_pop1", pop_pc_log.size() > np + 1 ? pop_pc_log[np + 1] : SENT, 64'h4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
